// File: rtl/r4_bf_pipe_if.sv
// Handshake and data bundle for the pipelined radix-4 butterfly.
// The slave side belongs to the butterfly, the master side to its environment.
interface r4_bf_pipe_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [8*WIDTH-1:0] x_in;
  logic               inverse;
  logic [1:0]         scale;
  logic               out_valid;
  logic               out_ready;
  logic [8*WIDTH-1:0] f_out;
  logic               sat;
  logic               sat_sticky;
  logic               sat_clr;

  modport slave (
    input  in_valid, x_in, inverse, scale,
    input  out_ready, sat_clr,
    output in_ready, out_valid, f_out,
    output sat, sat_sticky
  );

  modport master (
    output in_valid, x_in, inverse, scale,
    output out_ready, sat_clr,
    input  in_ready, out_valid, f_out,
    input  sat, sat_sticky
  );
endinterface

// File: rtl/r4_bf_pipe.sv
// Two-stage radix-4 butterfly with per-beat inverse/scale,
// rounding, saturation and sticky overflow flag.
module r4_bf_pipe #(
  parameter int WIDTH  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  r4_bf_pipe_if.slave bus
);
  localparam int W1 = WIDTH + 1;
  localparam int W2 = WIDTH + 2;
  localparam int W3 = WIDTH + 3;

  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic          adv1, adv2;
  logic          inv1_q, inv1_d;
  logic [1:0]    sc1_q, sc1_d;
  logic [W1-1:0] s1_q [8];
  logic [W1-1:0] s1_d [8];
  logic [8*WIDTH-1:0] f_q, f_d;
  logic          sat_q, sat_d;
  logic          stk_q, stk_d;

  logic [WIDTH-1:0] xc [8];
  logic [W2-1:0]    g  [8];
  logic [W2-1:0]    p, q, m, n;
  logic signed [W3-1:0] r [8];
  logic [7:0]       ovf;
  logic [WIDTH-1:0] res [8];

  function automatic logic [W1-1:0] ext1(
    input logic [WIDTH-1:0] v
  );
    return {v[WIDTH-1], v};
  endfunction

  function automatic logic [W2-1:0] ext2(
    input logic [W1-1:0] v
  );
    return {v[W1-1], v};
  endfunction

  always_comb begin
    adv2 = !v2_q || bus.out_ready;
    adv1 = !v1_q || adv2;
  end

  assign bus.in_ready = adv1;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      xc[i] = bus.x_in[i*WIDTH +: WIDTH];
    end
  end

  // s1 holds {a, b, c, d}, each as {re, im}
  always_comb begin
    v1_d   = v1_q;
    inv1_d = inv1_q;
    sc1_d  = sc1_q;
    for (int i = 0; i < 8; i++) begin
      s1_d[i] = s1_q[i];
    end
    if (adv1) begin
      v1_d = bus.in_valid;
    end
    if (adv1 && bus.in_valid) begin
      inv1_d = bus.inverse;
      sc1_d  = (bus.scale == 2'd3) ? 2'd2
                                   : bus.scale;
      for (int k = 0; k < 2; k++) begin
        s1_d[k]   = ext1(xc[k]) + ext1(xc[4+k]);
        s1_d[2+k] = ext1(xc[k]) - ext1(xc[4+k]);
        s1_d[4+k] = ext1(xc[2+k]) + ext1(xc[6+k]);
        s1_d[6+k] = ext1(xc[2+k]) - ext1(xc[6+k]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      g[k]   = ext2(s1_q[k]) + ext2(s1_q[4+k]);
      g[4+k] = ext2(s1_q[k]) - ext2(s1_q[4+k]);
    end
    p = ext2(s1_q[2]) + ext2(s1_q[7]);
    q = ext2(s1_q[3]) - ext2(s1_q[6]);
    m = ext2(s1_q[2]) - ext2(s1_q[7]);
    n = ext2(s1_q[3]) + ext2(s1_q[6]);
    g[2] = inv1_q ? m : p;
    g[3] = inv1_q ? n : q;
    g[6] = inv1_q ? p : m;
    g[7] = inv1_q ? q : n;
    for (int c = 0; c < 8; c++) begin
      // shift 1 rounds by +1, shift 2 by +2: the
      // rounding constant equals the shift code
      r[c] = {g[c][W2-1], g[c]} + W3'(sc1_q);
      r[c] = r[c] >>> sc1_q;
      ovf[c] = !((&r[c][W3-1:WIDTH-1]) ||
                 (~|r[c][W3-1:WIDTH-1]));
      res[c] = r[c][WIDTH-1:0];
      if (SAT_EN && ovf[c]) begin
        res[c] = r[c][W3-1]
          ? {1'b1, {(WIDTH-1){1'b0}}}
          : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  always_comb begin
    v2_d  = v2_q;
    f_d   = f_q;
    sat_d = sat_q;
    if (adv2) begin
      v2_d = v1_q;
    end
    if (adv2 && v1_q) begin
      for (int c = 0; c < 8; c++) begin
        f_d[c*WIDTH +: WIDTH] = res[c];
      end
      sat_d = |ovf;
    end
    stk_d = (stk_q && !bus.sat_clr) ||
            (v2_q && bus.out_ready && sat_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      inv1_q <= 1'b0;
      sc1_q  <= 2'd0;
      f_q    <= '0;
      sat_q  <= 1'b0;
      stk_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        s1_q[i] <= '0;
      end
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      inv1_q <= inv1_d;
      sc1_q  <= sc1_d;
      f_q    <= f_d;
      sat_q  <= sat_d;
      stk_q  <= stk_d;
      for (int i = 0; i < 8; i++) begin
        s1_q[i] <= s1_d[i];
      end
    end
  end

  assign bus.out_valid  = v2_q;
  assign bus.f_out      = f_q;
  assign bus.sat        = sat_q;
  assign bus.sat_sticky = stk_q;
endmodule

// File: tb/tb_r4_bf_pipe.sv
// Bench for r4_bf_pipe: saturating and wrapping instances
// driven in lockstep, checked by table and scoreboard.
module tb_r4_bf_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, inverse, out_ready, sat_clr;
  logic [127:0] x_in;
  logic [1:0]   scale;

  r4_bf_pipe_if #(.WIDTH(16)) b0 ();
  r4_bf_pipe_if #(.WIDTH(16)) b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.x_in      = x_in;
  assign b0.inverse   = inverse;
  assign b0.scale     = scale;
  assign b0.out_ready = out_ready;
  assign b0.sat_clr   = sat_clr;
  assign b1.in_valid  = in_valid;
  assign b1.x_in      = x_in;
  assign b1.inverse   = inverse;
  assign b1.scale     = scale;
  assign b1.out_ready = out_ready;
  assign b1.sat_clr   = sat_clr;

  r4_bf_pipe #(.WIDTH(16), .SAT_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  r4_bf_pipe #(.WIDTH(16), .SAT_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct packed {
    logic [127:0] x;
    bit           inv;
    logic [1:0]   sc;
    int e0r; int e1r; int e1i; int e3r; int e3i;
    bit esat;
    int w0r;
    bit wsat;
  } vec_t;

  vec_t tbl [12];
  int n_cmp = 0;
  int n_err = 0;
  int out_cnt = 0;
  bit saw_block = 0;
  logic [128:0] q0 [$];
  logic [128:0] q1 [$];
  logic [127:0] last0, last1;
  logic lsat0, lsat1;
  bit stall0 = 0, stall1 = 0;
  logic [129:0] hold0, hold1;

  task automatic chk_i(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(string nm, logic [129:0] act,
                       logic [129:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event, want none/other", nm);
  endtask

  function automatic int s16(logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [127:0] mk(
    int a0, int a1, int a2, int a3,
    int a4, int a5, int a6, int a7);
    logic [127:0] f;
    f = {a7[15:0], a6[15:0], a5[15:0], a4[15:0],
         a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    return f;
  endfunction

  // Direct DFT-style reference, returns {sat, f}
  function automatic logic [128:0] model(
    logic [127:0] x, bit inv, logic [1:0] sc, bit sen);
    int xr [4];
    int xi [4];
    int fv [8];
    int s, v;
    bit ov;
    logic [127:0] f;
    for (int k = 0; k < 4; k++) begin
      xr[k] = s16(x[32*k +: 16]);
      xi[k] = s16(x[32*k+16 +: 16]);
    end
    fv[0] = xr[0] + xr[1] + xr[2] + xr[3];
    fv[1] = xi[0] + xi[1] + xi[2] + xi[3];
    fv[4] = xr[0] - xr[1] + xr[2] - xr[3];
    fv[5] = xi[0] - xi[1] + xi[2] - xi[3];
    fv[2] = xr[0] + xi[1] - xr[2] - xi[3];
    fv[3] = xi[0] - xr[1] - xi[2] + xr[3];
    fv[6] = xr[0] - xi[1] - xr[2] + xi[3];
    fv[7] = xi[0] + xr[1] - xi[2] - xr[3];
    if (inv) begin
      v = fv[2]; fv[2] = fv[6]; fv[6] = v;
      v = fv[3]; fv[3] = fv[7]; fv[7] = v;
    end
    s = (sc == 2'd3) ? 2 : int'(sc);
    ov = 0;
    f = '0;
    for (int c = 0; c < 8; c++) begin
      v = fv[c];
      if (s > 0) v = (v + (1 << (s - 1))) >>> s;
      if (v > 32767 || v < -32768) begin
        ov = 1;
        if (sen) v = (v > 0) ? 32767 : -32768;
      end
      f[16*c +: 16] = v[15:0];
    end
    return {ov, f};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      stall0 = 0;
      stall1 = 0;
    end else begin
      if (in_valid && b0.in_ready) begin
        q0.push_back(model(x_in, inverse, scale, 1'b1));
        q1.push_back(model(x_in, inverse, scale, 1'b0));
      end
      if (!b0.in_ready) saw_block = 1;
      if (stall0)
        chk_w("hold0", {b0.out_valid, b0.sat, b0.f_out}, hold0);
      if (stall1)
        chk_w("hold1", {b1.out_valid, b1.sat, b1.f_out}, hold1);
      stall0 = b0.out_valid && !out_ready;
      stall1 = b1.out_valid && !out_ready;
      hold0 = {b0.out_valid, b0.sat, b0.f_out};
      hold1 = {b1.out_valid, b1.sat, b1.f_out};
      if (b0.out_valid && out_ready) begin
        if (q0.size() == 0) fail("unexpected_out0");
        else chk_w("out0", {1'b0, b0.sat, b0.f_out},
                   {1'b0, q0.pop_front()});
        last0 = b0.f_out;
        lsat0 = b0.sat;
        out_cnt++;
      end
      if (b1.out_valid && out_ready) begin
        if (q1.size() == 0) fail("unexpected_out1");
        else chk_w("out1", {1'b0, b1.sat, b1.f_out},
                   {1'b0, q1.pop_front()});
        last1 = b1.f_out;
        lsat1 = b1.sat;
      end
    end
  end

  task automatic send(logic [127:0] x, bit inv,
                      logic [1:0] sc);
    int t;
    bit ok;
    in_valid = 1;
    x_in = x;
    inverse = inv;
    scale = sc;
    t = 0;
    do begin
      @(negedge clk);
      ok = b0.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 50);
    in_valid = 0;
    if (!ok) fail("send_timeout");
  endtask

  task automatic wait_out(int n);
    int t;
    t = 0;
    while (out_cnt < n && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (out_cnt < n) fail("wait_out_timeout");
  endtask

  task automatic chk_rst(string nm);
    chk_i({nm, "_ov0"}, int'(b0.out_valid), 0);
    chk_i({nm, "_ov1"}, int'(b1.out_valid), 0);
    chk_i({nm, "_sat"}, int'(b0.sat), 0);
    chk_i({nm, "_stk0"}, int'(b0.sat_sticky), 0);
    chk_i({nm, "_stk1"}, int'(b1.sat_sticky), 0);
    chk_i({nm, "_ir"}, int'(b0.in_ready), 1);
    chk_w({nm, "_f"}, {2'b0, b0.f_out}, '0);
  endtask

  initial begin
    int n;
    logic [127:0] big;
    big = mk(32767, 0, 32767, 0, 32767, 0, 32767, 0);
    tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 2'd0,
                1, 1, 0, 1, 0, 1'b0, 1, 1'b0};
    tbl[1]  = '{mk(0, 0, 100, 0, 0, 0, 0, 0), 1'b0, 2'd0,
                100, 0, -100, 0, 100, 1'b0, 100, 1'b0};
    tbl[2]  = '{mk(0, 0, 100, 0, 0, 0, 0, 0), 1'b1, 2'd0,
                100, 0, 100, 0, -100, 1'b0, 100, 1'b0};
    tbl[3]  = '{mk(1000, 0, 1000, 0, 1000, 0, 1000, 0),
                1'b0, 2'd0, 4000, 0, 0, 0, 0, 1'b0, 4000, 1'b0};
    tbl[4]  = '{mk(1000, 0, 1000, 0, 1000, 0, 1000, 0),
                1'b0, 2'd2, 1000, 0, 0, 0, 0, 1'b0, 1000, 1'b0};
    tbl[5]  = '{mk(3, 0, 3, 0, 3, 0, 3, 0), 1'b0, 2'd1,
                6, 0, 0, 0, 0, 1'b0, 6, 1'b0};
    tbl[6]  = '{big, 1'b0, 2'd0,
                32767, 0, 0, 0, 0, 1'b1, -4, 1'b1};
    tbl[7]  = '{big, 1'b0, 2'd2,
                32767, 0, 0, 0, 0, 1'b0, 32767, 1'b0};
    tbl[8]  = '{mk(-32768, 0, -32768, 0, -32768, 0, -32768, 0),
                1'b0, 2'd0, -32768, 0, 0, 0, 0, 1'b1, 0, 1'b1};
    tbl[9]  = '{mk(1000, 0, 1000, 0, 1000, 0, 1000, 0),
                1'b0, 2'd3, 1000, 0, 0, 0, 0, 1'b0, 1000, 1'b0};
    tbl[10] = '{mk(5, -7, 2, 3, -1, 4, 6, -2), 1'b0, 2'd0,
                12, 11, -7, 1, -15, 1'b0, 12, 1'b0};
    tbl[11] = '{mk(-3, 0, 0, 0, 0, 0, 0, 0), 1'b0, 2'd1,
                -1, -1, 0, -1, 0, 1'b0, -1, 1'b0};

    rst = 1; in_valid = 0; x_in = '0; inverse = 0;
    scale = 0; out_ready = 1; sat_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_rst("reset");

    for (int i = 0; i < 12; i++) begin
      n = out_cnt;
      sat_clr = 1;
      send(tbl[i].x, tbl[i].inv, tbl[i].sc);
      sat_clr = 0;
      chk_i($sformatf("lat_early_%0d", i), int'(b0.out_valid), 0);
      @(posedge clk);
      #1;
      chk_i($sformatf("lat_valid_%0d", i), int'(b0.out_valid), 1);
      wait_out(n + 1);
      chk_i($sformatf("f0r_%0d", i), s16(last0[15:0]), tbl[i].e0r);
      chk_i($sformatf("f1r_%0d", i), s16(last0[47:32]), tbl[i].e1r);
      chk_i($sformatf("f1i_%0d", i), s16(last0[63:48]), tbl[i].e1i);
      chk_i($sformatf("f3r_%0d", i), s16(last0[111:96]), tbl[i].e3r);
      chk_i($sformatf("f3i_%0d", i), s16(last0[127:112]), tbl[i].e3i);
      chk_i($sformatf("sat_%0d", i), int'(lsat0), int'(tbl[i].esat));
      chk_i($sformatf("stk_%0d", i), int'(b0.sat_sticky),
            int'(tbl[i].esat));
      chk_i($sformatf("wrap_f0r_%0d", i), s16(last1[15:0]),
            tbl[i].w0r);
      chk_i($sformatf("wrap_sat_%0d", i), int'(lsat1),
            int'(tbl[i].wsat));
      chk_i($sformatf("wrap_stk_%0d", i), int'(b1.sat_sticky),
            int'(tbl[i].wsat));
    end

    n = out_cnt;
    saw_block = 0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send({$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    wait_out(n + 6);
    chk_i("stream_count", out_cnt - n, 6);
    chk_i("stream_in_ready_drop", int'(saw_block), 1);
    chk_i("stream_q_empty", q0.size(), 0);

    sat_clr = 1;
    @(posedge clk);
    #1 sat_clr = 0;
    n = out_cnt;
    send(big, 1'b0, 2'd0);
    wait_out(n + 1);
    chk_i("pre_rst_stk", int'(b0.sat_sticky), 1);
    out_ready = 0;
    send(mk(7, 1, 2, 3, 4, 5, 6, 8), 1'b0, 2'd0);
    send(mk(9, 9, 9, 9, 1, 1, 1, 1), 1'b1, 2'd1);
    chk_i("inflight_ov", int'(b0.out_valid), 1);
    chk_i("inflight_ir", int'(b0.in_ready), 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q0.delete();
    q1.delete();
    chk_rst("midrst");
    out_ready = 1;
    n = out_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk_i("flushed_none_out", out_cnt - n, 0);

    out_ready = 0;
    send(big, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    chk_i("clr_race_ov", int'(b0.out_valid), 1);
    chk_i("clr_race_pre", int'(b0.sat_sticky), 0);
    sat_clr = 1;
    out_ready = 1;
    @(posedge clk);
    #1 sat_clr = 0;
    chk_i("clr_race_stk0", int'(b0.sat_sticky), 1);
    chk_i("clr_race_stk1", int'(b1.sat_sticky), 1);
    sat_clr = 1;
    @(posedge clk);
    #1 sat_clr = 0;
    chk_i("clr_alone_stk", int'(b0.sat_sticky), 0);
    chk_i("final_q_empty", q0.size() + q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
